// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared encodings for the wash phase timer
package wash_pkg;

   // Phase encodings as driven on phase_sel by the washing-machine FSM
   localparam logic [1:0] PH_SOAK  = 2'b00;
   localparam logic [1:0] PH_WASH  = 2'b01;
   localparam logic [1:0] PH_RINSE = 2'b10;
   localparam logic [1:0] PH_SPIN  = 2'b11;

   // Timer FSM state encodings
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Front panel is {mode1,mode2,mode3,mode4}; lowest-numbered mode wins, none -> 0
   function automatic logic [1:0] mode_idx_f(input logic [3:0] mode_sel);
      logic [1:0] idx;
      idx = 2'd0;
      if (mode_sel[3]) begin
         idx = 2'd0;
      end else if (mode_sel[2]) begin
         idx = 2'd1;
      end else if (mode_sel[1]) begin
         idx = 2'd2;
      end else if (mode_sel[0]) begin
         idx = 2'd3;
      end
      return idx;
   endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// rtl/wash_tick_gen.sv - prescaler producing one tick every TICK_DIV enabled cycles
module wash_tick_gen
   import wash_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick only on a counting cycle, so a held prescaler never fires
   assign tick = en && (cnt_q == CNT_LAST);

   // Next count: clear wins, otherwise advance and wrap while enabled, else hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // Prescaler register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - per-mode/per-phase duration timer beside the wash FSM
module wash_phase_timer
   import wash_pkg::*;
#(
   parameter int unsigned         DUR_W    = 8,
   parameter int unsigned         TICK_DIV = 1000,
   parameter logic [DUR_W-1:0]    DEF_DUR  = DUR_W'(4)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             timer_enable,
   input  logic [1:0]       phase_sel,
   input  logic [3:0]       mode_sel,
   input  logic             power_on,
   input  logic             lid,
   input  logic             cancel,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [DUR_W-1:0] cfg_wdata,
   output logic             timer_done,
   output logic [DUR_W-1:0] remaining,
   output logic             busy,
   output logic             paused
);

   logic [2:0]       state_q, state_d;
   logic [DUR_W-1:0] rem_q, rem_d;
   logic [1:0]       phase_q, phase_d;
   logic             done_q, done_d;
   logic [DUR_W-1:0] dur_tbl_q [16];

   logic             abort;
   logic             counting;
   logic             phase_moved;
   logic             pause_req;
   logic             presc_en;
   logic             presc_clr;
   logic             tick;
   logic [3:0]       rd_addr;
   logic [DUR_W-1:0] load_val;

   // Entry selected by the current panel mode and FSM phase; read before any same-cycle write lands
   assign rd_addr  = {mode_idx_f(mode_sel), phase_sel};
   assign load_val = dur_tbl_q[rd_addr];

   // Cancel and loss of enable both force IDLE from any non-idle state
   assign abort       = cancel || (!timer_enable && (state_q != ST_IDLE));
   assign counting    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign phase_moved = (phase_sel != phase_q);
   assign pause_req   = !power_on || lid;

   // Prescaler advances only in RUN/PAUSE when nothing of higher priority applies;
   // the resume edge out of PAUSE counts so no tick is lost or added
   assign presc_en  = counting && !abort && !phase_moved && !pause_req;
   assign presc_clr = abort || (state_q == ST_LOAD);

   wash_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (presc_en),
      .clr   (presc_clr),
      .tick  (tick)
   );

   // Timer FSM and down-counter next state, priority: abort, phase change, pause, tick
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      phase_d = phase_q;
      done_d  = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (timer_enable) begin
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               rem_d   = load_val;
               phase_d = phase_sel;
               if (load_val == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN, ST_PAUSE: begin
               if (phase_moved) begin
                  state_d = ST_LOAD;
               end else if (pause_req) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_RUN;
                  if (tick) begin
                     if (rem_q <= DUR_W'(1)) begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        rem_d = rem_q - 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               rem_d = '0;
               if (phase_moved) begin
                  state_d = ST_LOAD;
               end
            end
            default: begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end
         endcase
      end
   end

   // FSM, counter, latched phase and done pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         phase_q <= PH_SOAK;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         phase_q <= phase_d;
         done_q  <= done_d;
      end
   end

   // Duration table: writable in any state, reverts to DEF_DUR on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            dur_tbl_q[i] <= DEF_DUR;
         end
      end else if (cfg_we) begin
         dur_tbl_q[cfg_addr] <= cfg_wdata;
      end
   end

   assign timer_done = done_q;
   assign remaining  = rem_q;
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign paused     = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb/tb_wash_phase_timer.sv - scoreboard bench for wash_phase_timer
module tb_wash_phase_timer;

   localparam int TDIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       timer_enable;
   logic [1:0] phase_sel;
   logic [3:0] mode_sel;
   logic       power_on;
   logic       lid;
   logic       cancel;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       timer_done;
   logic [7:0] remaining;
   logic       busy;
   logic       paused;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         sb[$];
   logic [7:0] tbl [16];
   logic [1:0] last_ph = 2'd0;
   logic       done_prev = 1'b0;

   wash_phase_timer #(
      .DUR_W    (8),
      .TICK_DIV (TDIV),
      .DEF_DUR  (8'd4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .timer_enable (timer_enable),
      .phase_sel    (phase_sel),
      .mode_sel     (mode_sel),
      .power_on     (power_on),
      .lid          (lid),
      .cancel       (cancel),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .timer_done   (timer_done),
      .remaining    (remaining),
      .busy         (busy),
      .paused       (paused)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int midx(input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (m[3-i]) return i;
      end
      return 0;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 16; i++) tbl[i] = 8'd4;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [7:0] v);
      cfg_addr  = a;
      cfg_wdata = v;
      cfg_we    = 1'b1;
      step(1);
      cfg_we    = 1'b0;
      tbl[a]    = v;
   endtask

   task automatic wait_until(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 2000) begin
         step(1);
         guard++;
      end
      if (cyc < target) chk("wait_budget", cyc, target);
   endtask

   // Enter a phase; done is expected 2 + D*TDIV + paused-edges cycles after the request
   task automatic run_phase(input logic [3:0] mode, input logic [1:0] ph, input int pa_in,
                            input int pl, input bit use_pwr, input bit wr_at_load,
                            input logic [7:0] wr_val);
      logic [3:0] idx;
      int d, start, expc, pa;
      idx = 4'(midx(mode) * 4 + int'(ph));
      d   = int'(tbl[idx]);
      pa  = pa_in;
      if (pa >= 0 && !(d > 0 && pa <= TDIV * d - 1)) pa = -1;
      if (timer_enable && ph == last_ph) begin
         timer_enable = 1'b0;
         step(1);
      end
      mode_sel     = mode;
      phase_sel    = ph;
      timer_enable = 1'b1;
      start        = cyc;
      expc         = start + 2 + TDIV * d + ((pa >= 0) ? pl : 0);
      sb.push_back(expc);
      step(1);
      if (wr_at_load) begin
         cfg_addr  = idx;
         cfg_wdata = wr_val;
         cfg_we    = 1'b1;
      end
      step(1);
      cfg_we = 1'b0;
      if (wr_at_load) tbl[idx] = wr_val;
      chk("load_remaining", int'(remaining), d);
      chk("load_busy", int'(busy), int'(d != 0));
      if (pa >= 0) begin
         step(pa);
         if (use_pwr) power_on = 1'b0;
         else         lid      = 1'b1;
         step(1);
         chk("pause_flag", int'(paused), 1);
         chk("pause_remaining", int'(remaining), d - pa / TDIV);
         step(pl - 1);
         power_on = 1'b1;
         lid      = 1'b0;
      end
      wait_until(expc);
      chk("done_remaining", int'(remaining), 0);
      chk("done_busy", int'(busy), 0);
      chk("done_paused", int'(paused), 0);
      last_ph = ph;
      step($urandom_range(0, 3));
   endtask

   // Start a phase of duration 4, cancel it at remaining=3, then let it reload and finish
   task automatic cancel_phase(input logic [3:0] mode, input logic [1:0] ph);
      logic [3:0] idx;
      int start, expc;
      idx = 4'(midx(mode) * 4 + int'(ph));
      cfg_write(idx, 8'd4);
      if (timer_enable && ph == last_ph) begin
         timer_enable = 1'b0;
         step(1);
      end
      mode_sel     = mode;
      phase_sel    = ph;
      timer_enable = 1'b1;
      step(2 + TDIV);
      chk("cancel_pre_remaining", int'(remaining), 3);
      cancel = 1'b1;
      step(1);
      chk("cancel_remaining", int'(remaining), 0);
      chk("cancel_busy", int'(busy), 0);
      chk("cancel_no_done", int'(timer_done), 0);
      cancel = 1'b0;
      start  = cyc;
      expc   = start + 2 + TDIV * int'(tbl[idx]);
      sb.push_back(expc);
      step(2);
      chk("reload_remaining", int'(remaining), int'(tbl[idx]));
      wait_until(expc);
      chk("reload_done_remaining", int'(remaining), 0);
      last_ph = ph;
      step(1);
   endtask

   // Monitor: every timer_done pulse must match the oldest expected done cycle
   always @(negedge clk) begin
      if (rst_n && timer_done) begin
         if (sb.size() == 0) chk("unexpected_done", cyc, -1);
         else                chk("done_cycle", cyc, sb.pop_front());
         chk("done_back_to_back", int'(done_prev), 0);
      end
      done_prev = rst_n && timer_done;
   end

   initial begin
      logic [3:0] m;
      logic [1:0] p;
      rst_n        = 1'b0;
      timer_enable = 1'b0;
      phase_sel    = 2'd0;
      mode_sel     = 4'd0;
      power_on     = 1'b1;
      lid          = 1'b0;
      cancel       = 1'b0;
      cfg_we       = 1'b0;
      cfg_addr     = 4'd0;
      cfg_wdata    = 8'd0;
      reset_model();
      step(2);
      chk("reset_remaining", int'(remaining), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_paused", int'(paused), 0);
      chk("reset_done", int'(timer_done), 0);
      rst_n = 1'b1;
      step(1);

      run_phase(4'b1000, 2'd0, -1, 1, 0, 0, 8'd0);
      cfg_write(4'b0101, 8'd3);
      run_phase(4'b0100, 2'd1, -1, 1, 0, 0, 8'd0);
      run_phase(4'b0100, 2'd2, -1, 1, 0, 0, 8'd0);
      run_phase(4'b0100, 2'd3, 9, 10, 0, 0, 8'd0);
      cfg_write(4'b0000, 8'd0);
      run_phase(4'b1000, 2'd0, -1, 1, 0, 0, 8'd0);
      cancel_phase(4'b1000, 2'd1);
      run_phase(4'b1000, 2'd2, -1, 1, 0, 1, 8'd2);
      run_phase(4'b1000, 2'd3, -1, 1, 0, 0, 8'd0);
      run_phase(4'b1000, 2'd2, -1, 1, 0, 0, 8'd0);

      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) cfg_write(4'($urandom), 8'($urandom_range(0, 6)));
         m = 4'($urandom);
         p = 2'($urandom);
         run_phase(m, p, ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20)),
                   int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 0, 8'd0);
      end

      // Reset in the middle of a phase: outputs clear and the table reverts
      cfg_write(4'b0010, 8'd6);
      if (last_ph == 2'd2) begin
         timer_enable = 1'b0;
         step(1);
      end
      mode_sel     = 4'b1000;
      phase_sel    = 2'd2;
      timer_enable = 1'b1;
      step(7);
      rst_n = 1'b0;
      #1;
      chk("midreset_remaining", int'(remaining), 0);
      chk("midreset_busy", int'(busy), 0);
      timer_enable = 1'b0;
      reset_model();
      step(1);
      rst_n = 1'b1;
      step(1);
      run_phase(4'b1000, 2'd2, -1, 1, 0, 0, 8'd0);

      step(5);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
